// File: rtl/ardff_ureg_if.sv
// Bus bundle for ardff_ureg: control/data inputs and registered outputs.
interface ardff_ureg_if #(
    parameter int WIDTH = 8
);
    logic             en;
    logic [2:0]       mode;
    logic [WIDTH-1:0] d;
    logic             sin;
    logic [WIDTH-1:0] q;
    logic             sout;
    logic             wrap;
    logic             ovf;
    logic             par;

    modport master (output en, mode, d, sin, input q, sout, wrap, ovf, par);
    modport slave  (input en, mode, d, sin, output q, sout, wrap, ovf, par);
endinterface

// File: rtl/ardff_ureg.sv
// Universal WIDTH-bit register: hold/load/shift/rotate/inc/dec with wrap pulse and sticky ovf.
// Optional registered even parity on par when ARDFF_UREG_PARITY_EN is defined.
module ardff_ureg #(
    parameter int               WIDTH     = 8,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic         clk,
    input  logic         reset,
    ardff_ureg_if.slave  bus
);
    typedef enum logic [2:0] {
        M_HOLD = 3'b000,
        M_LOAD = 3'b001,
        M_SHL  = 3'b010,
        M_SHR  = 3'b011,
        M_ROL  = 3'b100,
        M_ROR  = 3'b101,
        M_INC  = 3'b110,
        M_DEC  = 3'b111
    } mode_e;

    logic [WIDTH-1:0] r_q;
    logic             r_sout;
    logic             r_wrap;
    logic             r_ovf;

    logic [WIDTH-1:0] w_q_nxt;
    logic             w_sout_nxt;
    logic             w_wrap_nxt;
    logic             w_ovf_nxt;

    always_comb begin
        w_q_nxt    = r_q;
        w_sout_nxt = r_sout;
        w_wrap_nxt = 1'b0;
        w_ovf_nxt  = r_ovf;
        case (mode_e'(bus.mode))
            M_HOLD: ;
            M_LOAD: begin
                w_q_nxt   = bus.d;
                w_ovf_nxt = 1'b0;
            end
            M_SHL: begin
                w_q_nxt    = {r_q[WIDTH-2:0], bus.sin};
                w_sout_nxt = r_q[WIDTH-1];
            end
            M_SHR: begin
                w_q_nxt    = {bus.sin, r_q[WIDTH-1:1]};
                w_sout_nxt = r_q[0];
            end
            M_ROL: begin
                w_q_nxt    = {r_q[WIDTH-2:0], r_q[WIDTH-1]};
                w_sout_nxt = r_q[WIDTH-1];
            end
            M_ROR: begin
                w_q_nxt    = {r_q[0], r_q[WIDTH-1:1]};
                w_sout_nxt = r_q[0];
            end
            M_INC: begin
                w_q_nxt    = r_q + 1'b1;
                w_wrap_nxt = &r_q;
            end
            M_DEC: begin
                w_q_nxt    = r_q - 1'b1;
                w_wrap_nxt = ~|r_q;
            end
            default: ;
        endcase
        if (w_wrap_nxt)
            w_ovf_nxt = 1'b1;
    end

    // wrap is a pulse, so it drops on any edge that does not set it, enabled or not.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_q    <= RESET_VAL;
            r_sout <= 1'b0;
            r_wrap <= 1'b0;
            r_ovf  <= 1'b0;
        end else if (bus.en) begin
            r_q    <= w_q_nxt;
            r_sout <= w_sout_nxt;
            r_wrap <= w_wrap_nxt;
            r_ovf  <= w_ovf_nxt;
        end else begin
            r_wrap <= 1'b0;
        end
    end

    assign bus.q    = r_q;
    assign bus.sout = r_sout;
    assign bus.wrap = r_wrap;
    assign bus.ovf  = r_ovf;

`ifdef ARDFF_UREG_PARITY_EN
    logic r_par;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            r_par <= ^RESET_VAL;
        else if (bus.en)
            r_par <= ^w_q_nxt;
    end

    assign bus.par = r_par;
`else
    assign bus.par = 1'b0;
`endif
endmodule

// File: tb/tb_ardff_ureg.sv
// Self-checking bench for ardff_ureg: directed vector table, mid-cycle reset, random vs model.
module tb_ardff_ureg;
    localparam logic [2:0] HOLD = 3'd0, LOAD = 3'd1, SHL = 3'd2, SHR = 3'd3,
                           ROL  = 3'd4, ROR  = 3'd5, INC = 3'd6, DEC = 3'd7;

    logic clk;
    logic reset;
    int   checks;
    int   passes;

    ardff_ureg_if #(.WIDTH(8)) bus ();

    ardff_ureg #(.WIDTH(8), .RESET_VAL(8'h00)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       en;
        logic [2:0] mode;
        logic [7:0] d;
        logic       sin;
        logic [7:0] eq;
        logic       es;
        logic       ew;
        logic       eo;
    } vec_t;

    vec_t tbl[20];

    // behavioural model state
    int mq, msout, mwrap, movf;

    function automatic logic exp_par(input int v);
        logic [7:0] b;
        b = v[7:0];
`ifdef ARDFF_UREG_PARITY_EN
        return ^b;
`else
        return (b == 8'h00) && (b != 8'h00);
`endif
    endfunction

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    endtask

    task automatic chk_all(input string tag, input int q, input int s, input int w, input int o);
        chk({tag, ".q"},    bus.q,          8'(q));
        chk({tag, ".sout"}, {7'd0, bus.sout}, 8'(s));
        chk({tag, ".wrap"}, {7'd0, bus.wrap}, 8'(w));
        chk({tag, ".ovf"},  {7'd0, bus.ovf},  8'(o));
        chk({tag, ".par"},  {7'd0, bus.par},  {7'd0, exp_par(q)});
    endtask

    task automatic drive(input logic en, input logic [2:0] mode, input logic [7:0] d, input logic sin);
        bus.en = en; bus.mode = mode; bus.d = d; bus.sin = sin;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Model written from the operation rules with plain integer arithmetic.
    task automatic model(input logic en, input logic [2:0] mode, input int d, input int sin);
        if (!en) begin
            mwrap = 0;
            return;
        end
        mwrap = 0;
        case (mode)
            LOAD: begin mq = d; movf = 0; end
            SHL:  begin msout = mq / 128; mq = (mq * 2 + sin) % 256; end
            SHR:  begin msout = mq % 2;   mq = mq / 2 + sin * 128; end
            ROL:  begin msout = mq / 128; mq = (mq * 2) % 256 + mq / 128; end
            ROR:  begin msout = mq % 2;   mq = mq / 2 + (mq % 2) * 128; end
            INC:  begin mwrap = (mq == 255); mq = (mq + 1) % 256; end
            DEC:  begin mwrap = (mq == 0);   mq = (mq + 255) % 256; end
            default: ;
        endcase
        if (mwrap) movf = 1;
    endtask

    initial begin
        checks = 0;
        passes = 0;
        tbl[0]  = '{1'b1, LOAD, 8'h81, 1'b0, 8'h81, 1'b0, 1'b0, 1'b0};
        tbl[1]  = '{1'b1, SHL,  8'h00, 1'b0, 8'h02, 1'b1, 1'b0, 1'b0};
        tbl[2]  = '{1'b1, SHL,  8'h00, 1'b0, 8'h04, 1'b0, 1'b0, 1'b0};
        tbl[3]  = '{1'b1, LOAD, 8'h81, 1'b0, 8'h81, 1'b0, 1'b0, 1'b0};
        tbl[4]  = '{1'b1, ROR,  8'h00, 1'b0, 8'hC0, 1'b1, 1'b0, 1'b0};
        tbl[5]  = '{1'b0, ROR,  8'h00, 1'b0, 8'hC0, 1'b1, 1'b0, 1'b0};
        tbl[6]  = '{1'b1, LOAD, 8'hFE, 1'b0, 8'hFE, 1'b1, 1'b0, 1'b0};
        tbl[7]  = '{1'b1, INC,  8'h00, 1'b0, 8'hFF, 1'b1, 1'b0, 1'b0};
        tbl[8]  = '{1'b1, INC,  8'h00, 1'b0, 8'h00, 1'b1, 1'b1, 1'b1};
        tbl[9]  = '{1'b1, INC,  8'h00, 1'b0, 8'h01, 1'b1, 1'b0, 1'b1};
        tbl[10] = '{1'b1, LOAD, 8'h10, 1'b0, 8'h10, 1'b1, 1'b0, 1'b0};
        tbl[11] = '{1'b1, LOAD, 8'h00, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0};
        tbl[12] = '{1'b1, DEC,  8'h00, 1'b0, 8'hFF, 1'b1, 1'b1, 1'b1};
        tbl[13] = '{1'b0, DEC,  8'h00, 1'b0, 8'hFF, 1'b1, 1'b0, 1'b1};
        tbl[14] = '{1'b1, LOAD, 8'h07, 1'b0, 8'h07, 1'b1, 1'b0, 1'b0};
        tbl[15] = '{1'b1, INC,  8'h00, 1'b0, 8'h08, 1'b1, 1'b0, 1'b0};
        tbl[16] = '{1'b1, INC,  8'h00, 1'b0, 8'h09, 1'b1, 1'b0, 1'b0};
        tbl[17] = '{1'b1, SHR,  8'h00, 1'b1, 8'h84, 1'b1, 1'b0, 1'b0};
        tbl[18] = '{1'b1, ROL,  8'h00, 1'b0, 8'h09, 1'b1, 1'b0, 1'b0};
        tbl[19] = '{1'b1, HOLD, 8'hFF, 1'b1, 8'h09, 1'b1, 1'b0, 1'b0};

        // Power-on reset
        reset = 1'b0;
        drive(1'b0, HOLD, 8'h00, 1'b0);
        #12;
        chk_all("reset", 0, 0, 0, 0);
        reset = 1'b1;
        #1;

        // Directed vectors
        for (int i = 0; i < 20; i++) begin
            drive(tbl[i].en, tbl[i].mode, tbl[i].d, tbl[i].sin);
            step();
            chk_all($sformatf("vec%0d", i), tbl[i].eq, tbl[i].es, tbl[i].ew, tbl[i].eo);
        end

        // Mid-cycle reset right after a wrap edge: all state must drop before the next edge
        drive(1'b1, LOAD, 8'h00, 1'b0); step();
        drive(1'b1, DEC,  8'h00, 1'b0); step();
        chk_all("pre_rst", 8'hFF, 1, 1, 1);
        #2 reset = 1'b0;
        #1 chk_all("mid_rst", 0, 0, 0, 0);
        #2 reset = 1'b1;

        // Reset discards a loaded A5; first edge afterwards is a normal op
        drive(1'b1, LOAD, 8'hA5, 1'b0); step();
        chk_all("load_a5", 8'hA5, 0, 0, 0);
        drive(1'b0, HOLD, 8'h00, 1'b0);
        #2 reset = 1'b0;
        #1 chk_all("rst_a5", 0, 0, 0, 0);
        #2 reset = 1'b1;
        drive(1'b1, INC, 8'h00, 1'b0); step();
        chk_all("post_rst_inc", 1, 0, 0, 0);

        // Randomized run vs model
        mq = 1; msout = 0; mwrap = 0; movf = 0;
        for (int n = 0; n < 500; n++) begin
            logic       en;
            logic [2:0] mode;
            logic [7:0] d;
            logic       sin;
            en   = ($urandom_range(0, 7) != 0);
            mode = 3'($urandom_range(0, 7));
            // bias towards INC/DEC near the boundaries to exercise wrap
            if ($urandom_range(0, 9) == 0) begin
                mode = LOAD;
                d = ($urandom_range(0, 1) != 0) ? 8'hFE : 8'h01;
            end else begin
                d = 8'($urandom);
            end
            sin = 1'($urandom);
            drive(en, mode, d, sin);
            step();
            model(en, mode, int'(d), int'(sin));
            chk_all($sformatf("rnd%0d", n), mq, msout, mwrap, movf);
        end

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
